// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cnn_pkg
//  Description : Shared constants for the four-channel 3x3 conv datapath and
//                its result serializer, plus a lowest-set-bit helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package cnn_pkg;

  // Channel count and width of a channel index
  localparam int NCH      = 4;
  localparam int CHW      = $clog2(NCH);

  // Default accumulator width of the conv engine
  localparam int DEF_ACCW = 32;

  // Image geometry: valid 3x3 convolution over a 28x28 image
  localparam int IMG_W    = 28;
  localparam int K        = 3;
  localparam int OUT_W    = IMG_W - K + 1;
  localparam int OUT_PIX  = OUT_W * OUT_W;

  // Words delivered per feature-map frame (all channels)
  localparam int DEF_WORDS_PER_FRAME = NCH * OUT_PIX;

  // Index of the lowest set bit; returns 0 for an all-zero mask
  function automatic logic [CHW-1:0] lsb_idx(input logic [NCH-1:0] m);
    lsb_idx = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (m[i]) lsb_idx = CHW'(i);
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/result_group_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : result_group_fifo
//  Description : Synchronous FIFO of result groups {mask, 4 x ACCW data}.
//                Pointers carry one extra wrap bit so full/empty are exact.
//                A push while full is accepted only if a pop happens in the
//                same cycle (the slot being freed is the slot written).
//  Revision    : 1.0 - initial release
// ============================================================================
module result_group_fifo
  import cnn_pkg::*;
#(
  parameter int ACCW  = DEF_ACCW,
  parameter int DEPTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [NCH-1:0]          i_mask,
  input  logic [NCH*ACCW-1:0]     i_data,
  input  logic                    i_pop,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_level,
  output logic [NCH-1:0]          o_head_mask,
  output logic [NCH*ACCW-1:0]     o_head_data
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_pw = c_aw + 1;

  logic [NCH-1:0]      r_mask [DEPTH];
  logic [NCH*ACCW-1:0] r_data [DEPTH];
  logic [c_pw-1:0]     r_wptr;
  logic [c_pw-1:0]     r_rptr;

  logic                w_do_push;
  logic                w_do_pop;
  logic [c_aw-1:0]     w_waddr;
  logic [c_aw-1:0]     w_raddr;

  assign w_waddr     = r_wptr[c_aw-1:0];
  assign w_raddr     = r_rptr[c_aw-1:0];
  assign o_empty     = (r_wptr == r_rptr);
  assign o_full      = (r_wptr[c_aw] != r_rptr[c_aw]) && (w_waddr == w_raddr);
  assign o_level     = r_wptr - r_rptr;
  assign w_do_pop    = i_pop & ~o_empty;
  assign w_do_push   = i_push & (~o_full | w_do_pop);
  assign o_head_mask = r_mask[w_raddr];
  assign o_head_data = r_data[w_raddr];

  // Pointer update; reset empties the FIFO
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + c_pw'(1);
      if (w_do_pop)  r_rptr <= r_rptr + c_pw'(1);
    end
  end

  // Storage write; contents are only meaningful between the pointers
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mask[w_waddr] <= i_mask;
      r_data[w_waddr] <= i_data;
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : conv_result_serializer
//  Description : Buffers per-cycle conv result groups and serializes them one
//                word at a time (lowest pending channel first) onto a
//                valid/ready stream, with frame-end marking and a sticky
//                overflow flag for groups dropped while the buffer is full.
//  Revision    : 1.0 - initial release
// ============================================================================
module conv_result_serializer
  import cnn_pkg::*;
#(
  parameter int ACCW            = DEF_ACCW,
  parameter int DEPTH           = 8,
  parameter int WORDS_PER_FRAME = DEF_WORDS_PER_FRAME
) (
  input  logic                    iClk,
  input  logic                    iRsn,
  input  logic [NCH-1:0]          iValid4,
  input  logic signed [ACCW-1:0]  iData0,
  input  logic signed [ACCW-1:0]  iData1,
  input  logic signed [ACCW-1:0]  iData2,
  input  logic signed [ACCW-1:0]  iData3,
  output logic                    oValid,
  input  logic                    iReady,
  output logic signed [ACCW-1:0]  oData,
  output logic [CHW-1:0]          oChan,
  output logic                    oLast,
  output logic                    oFrameDone,
  output logic                    oOverflow,
  output logic [$clog2(DEPTH):0]  oLevel
);

  localparam int c_cw = $clog2(WORDS_PER_FRAME);
  localparam logic [c_cw-1:0] c_last_cnt = c_cw'(WORDS_PER_FRAME - 1);

  // Bits of the head group already delivered; the working mask is the
  // head mask with these removed, so it only depends on registered state.
  logic [NCH-1:0]      r_sent;
  logic [c_cw-1:0]     r_cnt;
  logic                r_frame_done;
  logic                r_ovf;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic                w_hs;
  logic                w_cnt_last;
  logic [NCH-1:0]      w_head_mask;
  logic [NCH*ACCW-1:0] w_head_data;
  logic [NCH-1:0]      w_work;
  logic [NCH-1:0]      w_bit;
  logic [NCH-1:0]      w_rem;
  logic [CHW-1:0]      w_k;

  assign w_push     = |iValid4;
  assign w_work     = w_head_mask & ~r_sent;
  assign w_k        = lsb_idx(w_work);
  assign w_bit      = {{(NCH-1){1'b0}}, 1'b1} << w_k;
  assign w_rem      = w_work & ~w_bit;
  assign w_hs       = ~w_empty & iReady;
  assign w_pop      = w_hs & (w_rem == '0);
  assign w_cnt_last = (r_cnt == c_last_cnt);

  assign oValid     = ~w_empty;
  assign oChan      = w_empty ? '0 : w_k;
  assign oData      = w_empty ? '0 : w_head_data[32'(w_k) * ACCW +: ACCW];
  assign oLast      = ~w_empty & w_cnt_last;
  assign oFrameDone = r_frame_done;
  assign oOverflow  = r_ovf;

  result_group_fifo #(
    .ACCW  (ACCW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk       (iClk),
    .i_rst_n     (iRsn),
    .i_push      (w_push),
    .i_mask      (iValid4),
    .i_data      ({iData3, iData2, iData1, iData0}),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_level     (oLevel),
    .o_head_mask (w_head_mask),
    .o_head_data (w_head_data)
  );

  // Track delivered channels of the head group; clear when it is popped
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_sent <= '0;
    end else if (w_hs) begin
      r_sent <= w_pop ? '0 : (r_sent | w_bit);
    end
  end

  // Frame word counter and registered end-of-frame pulse
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_cnt        <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_hs & w_cnt_last;
      if (w_hs) r_cnt <= w_cnt_last ? '0 : (r_cnt + c_cw'(1));
    end
  end

  // Sticky overflow: a group arrived while full with no pop to make room
  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      r_ovf <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_ovf <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_conv_result_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_conv_result_serializer
//  Description : Directed self-checking bench for conv_result_serializer.
//                Inputs change and outputs are sampled on the falling edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_result_serializer;

  localparam int ACCW = 32;
  localparam int DEPTH = 8;
  localparam int WPF = 2704;

  logic              iClk;
  logic              iRsn;
  logic [3:0]        iValid4;
  logic signed [31:0] iData0, iData1, iData2, iData3;
  logic              oValid;
  logic              iReady;
  logic signed [31:0] oData;
  logic [1:0]        oChan;
  logic              oLast;
  logic              oFrameDone;
  logic              oOverflow;
  logic [3:0]        oLevel;

  int checks = 0;
  int errors = 0;

  conv_result_serializer #(
    .ACCW            (ACCW),
    .DEPTH           (DEPTH),
    .WORDS_PER_FRAME (WPF)
  ) dut (
    .iClk       (iClk),
    .iRsn       (iRsn),
    .iValid4    (iValid4),
    .iData0     (iData0),
    .iData1     (iData1),
    .iData2     (iData2),
    .iData3     (iData3),
    .oValid     (oValid),
    .iReady     (iReady),
    .oData      (oData),
    .oChan      (oChan),
    .oLast      (oLast),
    .oFrameDone (oFrameDone),
    .oOverflow  (oOverflow),
    .oLevel     (oLevel)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reset values of every output while iRsn is low
  task automatic test_reset();
    iRsn = 1'b0; iValid4 = 4'b0; iReady = 1'b0;
    iData0 = 0; iData1 = 0; iData2 = 0; iData3 = 0;
    #1;
    checks++;
    if (oValid !== 1'b0 || oLevel !== 4'd0 || oOverflow !== 1'b0 ||
        oFrameDone !== 1'b0 || oLast !== 1'b0 || oData !== 32'sd0 || oChan !== 2'd0) begin
      errors++;
      $display("FAIL reset: got v=%0b lvl=%0d ovf=%0b fd=%0b last=%0b data=%0d chan=%0d expected all 0",
               oValid, oLevel, oOverflow, oFrameDone, oLast, oData, oChan);
    end
    @(negedge iClk);
    iRsn = 1'b1;
    @(negedge iClk);
  endtask

  // Full group drains in channel order at one word per cycle
  task automatic test_full_group();
    int exp_d [4] = '{10, -20, 30, -40};
    iReady = 1'b1;
    iValid4 = 4'b1111; iData0 = 10; iData1 = -20; iData2 = 30; iData3 = -40;
    @(negedge iClk);
    iValid4 = 4'b0;
    checks++;
    if (oLevel !== 4'd1) begin
      errors++; $display("FAIL full_level1: got %0d expected 1", oLevel);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (oValid !== 1'b1 || oChan !== 2'(i) || oData !== exp_d[i]) begin
        errors++;
        $display("FAIL full_word%0d: got v=%0b chan=%0d data=%0d expected v=1 chan=%0d data=%0d",
                 i, oValid, oChan, oData, i, exp_d[i]);
      end
      @(negedge iClk);
    end
    checks++;
    if (oValid !== 1'b0 || oLevel !== 4'd0) begin
      errors++; $display("FAIL full_drained: got v=%0b lvl=%0d expected v=0 lvl=0", oValid, oLevel);
    end
  endtask

  // Sparse mask: only set channels are emitted, back to back
  task automatic test_sparse();
    iReady = 1'b1;
    iValid4 = 4'b1010; iData0 = 99; iData1 = 7; iData2 = 98; iData3 = -1;
    @(negedge iClk);
    iValid4 = 4'b0;
    checks++;
    if (oValid !== 1'b1 || oChan !== 2'd1 || oData !== 7) begin
      errors++; $display("FAIL sparse_w0: got v=%0b chan=%0d data=%0d expected v=1 chan=1 data=7", oValid, oChan, oData);
    end
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b1 || oChan !== 2'd3 || oData !== -1) begin
      errors++; $display("FAIL sparse_w1: got v=%0b chan=%0d data=%0d expected v=1 chan=3 data=-1", oValid, oChan, oData);
    end
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b0) begin
      errors++; $display("FAIL sparse_end: got v=%0b expected 0", oValid);
    end
  endtask

  // Output holds while iReady is low, resumes immediately when it rises
  task automatic test_backpressure();
    iReady = 1'b0;
    iValid4 = 4'b1111; iData0 = 1; iData1 = 2; iData2 = 3; iData3 = 4;
    @(negedge iClk);
    iValid4 = 4'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (oValid !== 1'b1 || oChan !== 2'd0 || oData !== 1) begin
        errors++; $display("FAIL bp_hold%0d: got v=%0b chan=%0d data=%0d expected v=1 chan=0 data=1", i, oValid, oChan, oData);
      end
      if (i < 4) @(negedge iClk);
    end
    iReady = 1'b1;
    for (int i = 1; i < 4; i++) begin
      @(negedge iClk);
      checks++;
      if (oValid !== 1'b1 || oChan !== 2'(i) || oData !== i + 1) begin
        errors++; $display("FAIL bp_resume%0d: got v=%0b chan=%0d data=%0d expected v=1 chan=%0d data=%0d", i, oValid, oChan, oData, i, i + 1);
      end
    end
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b0) begin
      errors++; $display("FAIL bp_end: got v=%0b expected 0", oValid);
    end
  endtask

  // Nine pushes into an eight-deep FIFO with no drain: last one dropped
  task automatic test_overflow();
    int nwords = 0;
    int nbad = 0;
    iReady = 1'b0;
    for (int g = 1; g <= 9; g++) begin
      iValid4 = 4'b0001; iData0 = 100 + g; iData1 = 0; iData2 = 0; iData3 = 0;
      @(negedge iClk);
      if (g == 8) begin
        checks++;
        if (oLevel !== 4'd8 || oOverflow !== 1'b0) begin
          errors++; $display("FAIL ovf_at8: got lvl=%0d ovf=%0b expected lvl=8 ovf=0", oLevel, oOverflow);
        end
      end
    end
    iValid4 = 4'b0;
    checks++;
    if (oLevel !== 4'd8 || oOverflow !== 1'b1) begin
      errors++; $display("FAIL ovf_at9: got lvl=%0d ovf=%0b expected lvl=8 ovf=1", oLevel, oOverflow);
    end
    iReady = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (oValid === 1'b1) begin
        if (oChan !== 2'd0 || oData !== 101 + nwords) nbad++;
        nwords++;
      end
      @(negedge iClk);
    end
    checks++;
    if (nwords != 8 || nbad != 0) begin
      errors++; $display("FAIL ovf_drain: got words=%0d bad=%0d expected words=8 bad=0", nwords, nbad);
    end
    checks++;
    if (oOverflow !== 1'b1 || oLevel !== 4'd0) begin
      errors++; $display("FAIL ovf_sticky: got ovf=%0b lvl=%0d expected ovf=1 lvl=0", oOverflow, oLevel);
    end
  endtask

  // Asynchronous reset while three groups are buffered
  task automatic test_reset_mid_drain();
    iReady = 1'b0;
    for (int g = 0; g < 3; g++) begin
      iValid4 = 4'b1111; iData0 = g; iData1 = g; iData2 = g; iData3 = g;
      @(negedge iClk);
    end
    iValid4 = 4'b0;
    checks++;
    if (oLevel !== 4'd3) begin
      errors++; $display("FAIL rst_pre_level: got %0d expected 3", oLevel);
    end
    #2 iRsn = 1'b0;
    #1;
    checks++;
    if (oValid !== 1'b0 || oLevel !== 4'd0 || oOverflow !== 1'b0 || oData !== 32'sd0) begin
      errors++; $display("FAIL rst_async: got v=%0b lvl=%0d ovf=%0b data=%0d expected all 0", oValid, oLevel, oOverflow, oData);
    end
    @(negedge iClk);
    iRsn = 1'b1;
    @(negedge iClk);
    checks++;
    if (oValid !== 1'b0 || oLevel !== 4'd0) begin
      errors++; $display("FAIL rst_release: got v=%0b lvl=%0d expected v=0 lvl=0", oValid, oLevel);
    end
  endtask

  // Full frame right after a reset: oLast exactly on word 2704
  task automatic test_frame();
    int words = 0;
    int bad = 0;
    int groups = 0;
    int last_cnt = 0;
    int last_at = -1;
    int fd_cnt = 0;
    int fd_at = -1;
    iReady = 1'b1;
    for (int c = 0; c < WPF + 12; c++) begin
      if (oValid === 1'b1) begin
        if (oData !== words || oChan !== 2'(words % 4) || oLast !== (words == WPF - 1)) bad++;
        if (oLast === 1'b1) begin
          last_cnt++; last_at = c;
          if (oChan !== 2'd3) bad++;
        end
        words++;
      end
      if (oFrameDone === 1'b1) begin
        fd_cnt++; fd_at = c;
      end
      if ((c % 4) == 0 && groups < WPF / 4) begin
        iValid4 = 4'b1111;
        iData0 = groups * 4; iData1 = groups * 4 + 1;
        iData2 = groups * 4 + 2; iData3 = groups * 4 + 3;
        groups++;
      end else begin
        iValid4 = 4'b0;
      end
      @(negedge iClk);
    end
    checks++;
    if (words != WPF || bad != 0) begin
      errors++; $display("FAIL frame_words: got words=%0d bad=%0d expected words=%0d bad=0", words, bad, WPF);
    end
    checks++;
    if (last_cnt != 1) begin
      errors++; $display("FAIL frame_last: got count=%0d expected 1", last_cnt);
    end
    checks++;
    if (fd_cnt != 1 || fd_at != last_at + 1) begin
      errors++; $display("FAIL frame_done: got pulses=%0d at=%0d expected 1 at %0d", fd_cnt, fd_at, last_at + 1);
    end
    iValid4 = 4'b1111; iData0 = 5000; iData1 = 5001; iData2 = 5002; iData3 = 5003;
    @(negedge iClk);
    iValid4 = 4'b0;
    checks++;
    if (oValid !== 1'b1 || oLast !== 1'b0 || oChan !== 2'd0 || oData !== 5000) begin
      errors++; $display("FAIL frame_next: got v=%0b last=%0b chan=%0d data=%0d expected v=1 last=0 chan=0 data=5000", oValid, oLast, oChan, oData);
    end
    repeat (4) @(negedge iClk);
    checks++;
    if (oValid !== 1'b0 || oLevel !== 4'd0) begin
      errors++; $display("FAIL frame_next_drain: got v=%0b lvl=%0d expected v=0 lvl=0", oValid, oLevel);
    end
  endtask

  initial begin
    test_reset();
    test_full_group();
    test_sparse();
    test_backpressure();
    test_overflow();
    test_reset_mid_drain();
    test_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
